// File: rtl/if_fetch_stage_pkg.sv
// Shared constants for the instruction-fetch stage.
//   IfPcWidth   : PC / instruction-memory address width
//   IfInstWidth : instruction word width
//   IfNopInst   : bubble encoding presented to decode when the IF/ID bundle is invalid
package if_fetch_stage_pkg;

  localparam int unsigned IfPcWidth   = 32;
  localparam int unsigned IfInstWidth = 32;
  localparam logic [IfInstWidth-1:0] IfNopInst = 32'h0000_0013;

endpackage

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage sitting directly after the PC generator.
// Issues reads to a synchronous instruction memory (data returns one cycle after
// imem_en), pairs each returning word with the PC it was fetched from, and presents a
// registered IF/ID bundle to decode. A one-entry hold buffer catches the single response
// that can land while decode is stalled; pc_jump squashes wrong-path fetches.
// Ports:
//   clk, rst           clock, synchronous active-high reset
//   work_ena           core enable; low = no new fetches
//   stall              hold IF/ID, issue nothing new
//   pc_jump, pc_target redirect this cycle to pc_target (flushes in-flight work)
//   pc                 sequential fetch PC
//   imem_en/imem_addr  memory read request
//   imem_rdata         memory read data (one cycle after the request)
//   id_valid/id_pc/id_inst  registered IF/ID bundle
import if_fetch_stage_pkg::*;

module if_fetch_stage #(
  parameter int unsigned               PC_WIDTH   = IfPcWidth,
  parameter int unsigned               INST_WIDTH = IfInstWidth,
  parameter logic [INST_WIDTH-1:0]     NOP_INST   = IfNopInst
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  work_ena,
  input  logic                  stall,
  input  logic                  pc_jump,
  input  logic [PC_WIDTH-1:0]   pc_target,
  input  logic [PC_WIDTH-1:0]   pc,
  output logic                  imem_en,
  output logic [PC_WIDTH-1:0]   imem_addr,
  input  logic [INST_WIDTH-1:0] imem_rdata,
  output logic                  id_valid,
  output logic [PC_WIDTH-1:0]   id_pc,
  output logic [INST_WIDTH-1:0] id_inst
);

  // Request tracker: remembers which address the word on imem_rdata belongs to.
  logic                  req_vld_q, req_vld_d;
  logic [PC_WIDTH-1:0]   req_pc_q, req_pc_d;

  // Hold buffer for the response that arrives during a stall.
  logic                  hold_vld_q, hold_vld_d;
  logic [PC_WIDTH-1:0]   hold_pc_q, hold_pc_d;
  logic [INST_WIDTH-1:0] hold_inst_q, hold_inst_d;

  logic                  id_valid_q, id_valid_d;
  logic [PC_WIDTH-1:0]   id_pc_q, id_pc_d;
  logic [INST_WIDTH-1:0] id_inst_q, id_inst_d;

  always_comb begin
    imem_addr = pc_jump ? pc_target : pc;
    // A redirect overrides stall so the target fetch is never lost.
    imem_en   = ~rst & work_ena & (pc_jump | ~stall);
  end

  always_comb begin
    req_vld_d   = imem_en;
    req_pc_d    = imem_addr;
    hold_vld_d  = hold_vld_q;
    hold_pc_d   = hold_pc_q;
    hold_inst_d = hold_inst_q;
    id_valid_d  = id_valid_q;
    id_pc_d     = id_pc_q;
    id_inst_d   = id_inst_q;

    if (pc_jump) begin
      // Wrong path: drop held and in-flight responses, present a bubble.
      id_valid_d = 1'b0;
      id_inst_d  = NOP_INST;
      hold_vld_d = 1'b0;
    end else if (stall) begin
      // No request goes out while stalled, so at most one response can land here.
      if (req_vld_q) begin
        hold_vld_d  = 1'b1;
        hold_pc_d   = req_pc_q;
        hold_inst_d = imem_rdata;
      end
    end else if (hold_vld_q) begin
      id_valid_d = 1'b1;
      id_pc_d    = hold_pc_q;
      id_inst_d  = hold_inst_q;
      hold_vld_d = 1'b0;
    end else if (req_vld_q) begin
      id_valid_d = 1'b1;
      id_pc_d    = req_pc_q;
      id_inst_d  = imem_rdata;
    end else begin
      id_valid_d = 1'b0;
      id_inst_d  = NOP_INST;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      req_vld_q   <= 1'b0;
      req_pc_q    <= '0;
      hold_vld_q  <= 1'b0;
      hold_pc_q   <= '0;
      hold_inst_q <= NOP_INST;
      id_valid_q  <= 1'b0;
      id_pc_q     <= '0;
      id_inst_q   <= NOP_INST;
    end else begin
      req_vld_q   <= req_vld_d;
      req_pc_q    <= req_pc_d;
      hold_vld_q  <= hold_vld_d;
      hold_pc_q   <= hold_pc_d;
      hold_inst_q <= hold_inst_d;
      id_valid_q  <= id_valid_d;
      id_pc_q     <= id_pc_d;
      id_inst_q   <= id_inst_d;
    end
  end

  assign id_valid = id_valid_q;
  assign id_pc    = id_pc_q;
  assign id_inst  = id_inst_q;

`ifndef SYNTHESIS
  // The hold buffer drains before a new response can arrive once the stall lifts.
  hold_req_exclusive: assert property (@(posedge clk) disable iff (rst)
    !(hold_vld_q && req_vld_q && !stall));
`endif

endmodule

// File: tb/tb_if_fetch_stage.sv
// Bench for if_fetch_stage: directed fetch sequence, a sync memory model returning
// addr | 0xA000, a scoreboard queue of expected (pc, inst) pairs and a monitor that pops
// whenever the IF/ID bundle is updated with a valid entry.
module tb_if_fetch_stage;

  localparam logic [31:0] Nop = 32'h0000_0013;

  logic        clk;
  logic        rst;
  logic        work_ena;
  logic        stall;
  logic        pc_jump;
  logic [31:0] pc_target;
  logic [31:0] pc;
  logic        imem_en;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        id_valid;
  logic [31:0] id_pc;
  logic [31:0] id_inst;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
  } exp_t;
  exp_t exp_q[$];

  if_fetch_stage dut (
    .clk        (clk),
    .rst        (rst),
    .work_ena   (work_ena),
    .stall      (stall),
    .pc_jump    (pc_jump),
    .pc_target  (pc_target),
    .pc         (pc),
    .imem_en    (imem_en),
    .imem_addr  (imem_addr),
    .imem_rdata (imem_rdata),
    .id_valid   (id_valid),
    .id_pc      (id_pc),
    .id_inst    (id_inst)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous instruction memory: mem[a] = a | 0xA000.
  initial imem_rdata = 32'h0;
  always @(posedge clk) begin
    if (imem_en) imem_rdata <= imem_addr | 32'h0000_A000;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic push(input logic [31:0] a);
    exp_t e;
    e.pc   = a;
    e.inst = a | 32'h0000_A000;
    exp_q.push_back(e);
  endtask

  task automatic drive(input logic r, input logic we, input logic st, input logic jp,
                       input logic [31:0] tgt, input logic [31:0] p);
    @(negedge clk);
    rst       = r;
    work_ena  = we;
    stall     = st;
    pc_jump   = jp;
    pc_target = tgt;
    pc        = p;
  endtask

  // Monitor: IF/ID is rewritten on every edge that is not reset and not a plain stall.
  initial begin
    logic upd;
    exp_t e;
    forever begin
      @(posedge clk);
      upd = !rst && (pc_jump || !stall);
      #1;
      if (upd) begin
        if (id_valid) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_id actual_pc=%h required=none", id_pc);
          end else begin
            e = exp_q.pop_front();
            chk("sb_id_pc", id_pc, e.pc);
            chk("sb_id_inst", id_inst, e.inst);
          end
        end else begin
          chk("sb_bubble_inst", id_inst, Nop);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; work_ena = 1'b0; stall = 1'b0; pc_jump = 1'b0;
    pc_target = 32'h0; pc = 32'h0;

    // Reset, with work_ena high to show imem_en is held low.
    drive(1, 1, 0, 0, 32'h0, 32'h0);
    drive(1, 1, 0, 0, 32'h0, 32'h0);
    drive(1, 1, 0, 0, 32'h0, 32'h0);
    #1;
    chk("rst_id_valid", {31'b0, id_valid}, 32'd0);
    chk("rst_id_pc", id_pc, 32'h0);
    chk("rst_id_inst", id_inst, Nop);
    chk("rst_imem_en", {31'b0, imem_en}, 32'd0);

    // Sequential fetch 0, 4, 8.
    drive(0, 1, 0, 0, 32'h0, 32'h0); push(32'h0);
    #1;
    chk("run_imem_en", {31'b0, imem_en}, 32'd1);
    chk("run_imem_addr", imem_addr, 32'h0);
    drive(0, 1, 0, 0, 32'h0, 32'h4); push(32'h4);
    drive(0, 1, 0, 0, 32'h0, 32'h8); push(32'h8);
    chk("lat_id_valid", {31'b0, id_valid}, 32'd1);
    chk("lat_id_pc", id_pc, 32'h0);

    // One-cycle stall while 8 is in flight.
    drive(0, 1, 1, 0, 32'h0, 32'hC);
    #1;
    chk("stall1_imem_en", {31'b0, imem_en}, 32'd0);
    drive(0, 1, 0, 0, 32'h0, 32'hC); push(32'hC);
    chk("stall1_id_pc_held", id_pc, 32'h4);
    drive(0, 1, 0, 0, 32'h0, 32'h10); push(32'h10);

    // Five-cycle stall while 0x10 is in flight.
    for (int i = 0; i < 5; i++) begin
      drive(0, 1, 1, 0, 32'h0, 32'h14);
      #1;
      chk("stall5_imem_en", {31'b0, imem_en}, 32'd0);
      chk("stall5_id_pc", id_pc, 32'hC);
      chk("stall5_id_valid", {31'b0, id_valid}, 32'd1);
      if (i > 0) chk("stall5_hold_vld", {31'b0, dut.hold_vld_q}, 32'd1);
    end
    drive(0, 1, 0, 0, 32'h0, 32'h14); push(32'h14);
    chk("stall5_end_id_pc", id_pc, 32'hC);
    drive(0, 1, 0, 0, 32'h0, 32'h18);

    // Redirect to 0x100: in-flight 0x18 and sequential 0x1C are squashed.
    drive(0, 1, 0, 1, 32'h100, 32'h1C); push(32'h100);
    #1;
    chk("jump_imem_en", {31'b0, imem_en}, 32'd1);
    chk("jump_imem_addr", imem_addr, 32'h100);
    drive(0, 1, 0, 0, 32'h0, 32'h104); push(32'h104);
    chk("jump_bubble_valid", {31'b0, id_valid}, 32'd0);
    chk("jump_bubble_inst", id_inst, Nop);
    drive(0, 1, 0, 0, 32'h0, 32'h108);

    // Stall captures 0x108, then jump+stall clears it and fetches 0x200.
    drive(0, 1, 1, 0, 32'h0, 32'h10C);
    drive(0, 1, 1, 1, 32'h200, 32'h10C); push(32'h200);
    chk("js_hold_before", {31'b0, dut.hold_vld_q}, 32'd1);
    #1;
    chk("js_imem_en", {31'b0, imem_en}, 32'd1);
    chk("js_imem_addr", imem_addr, 32'h200);
    drive(0, 1, 0, 0, 32'h0, 32'h204); push(32'h204);
    chk("js_hold_cleared", {31'b0, dut.hold_vld_q}, 32'd0);
    chk("js_id_valid", {31'b0, id_valid}, 32'd0);
    drive(0, 1, 0, 0, 32'h0, 32'h208);

    // Reset during a stall with the hold buffer full.
    drive(0, 1, 1, 0, 32'h0, 32'h20C);
    drive(1, 1, 1, 0, 32'h0, 32'h20C);
    chk("rs_hold_before", {31'b0, dut.hold_vld_q}, 32'd1);
    drive(0, 1, 0, 0, 32'h0, 32'h0); push(32'h0);
    chk("rs_id_valid", {31'b0, id_valid}, 32'd0);
    chk("rs_id_inst", id_inst, Nop);
    chk("rs_id_pc", id_pc, 32'h0);
    chk("rs_hold_vld", {31'b0, dut.hold_vld_q}, 32'd0);
    drive(0, 1, 0, 0, 32'h0, 32'h4); push(32'h4);

    // work_ena low: in-flight response drains, then bubbles.
    drive(0, 0, 0, 0, 32'h0, 32'h8);
    #1;
    chk("we0_imem_en", {31'b0, imem_en}, 32'd0);
    drive(0, 0, 0, 0, 32'h0, 32'h8);
    drive(0, 0, 0, 0, 32'h0, 32'h8);
    chk("we0_bubble_valid", {31'b0, id_valid}, 32'd0);
    drive(0, 0, 0, 0, 32'h0, 32'h8);
    drive(0, 0, 0, 0, 32'h0, 32'h8);

    chk("sb_drained", exp_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
